// File: rtl/image_proc_pkg.sv
// Shared types and constants for the image line feeder and its pixel skid buffer.
package image_proc_pkg;

    localparam int unsigned PIX_W      = 8;
    localparam int unsigned CREDIT_W   = 3;
    // Output register plus two skid entries.
    localparam int unsigned SKID_DEPTH = 3;
    localparam int unsigned SKID_CNT_W = $clog2(SKID_DEPTH + 1);

    typedef logic [PIX_W-1:0] pixel_t;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_PRELOAD  = 3'd1,
        ST_WAIT     = 3'd2,
        ST_LINE     = 3'd3,
        ST_PAD_WAIT = 3'd4,
        ST_PAD      = 3'd5,
        ST_DRAIN    = 3'd6
    } feeder_state_e;

    // Tag travelling alongside a read request through the memory latency.
    typedef struct packed {
        logic vld;
        logic zero;
    } rd_tag_t;

endpackage

// File: rtl/pixel_skid_buffer.sv
// Pixel FIFO with a registered output stage and two skid entries behind it; absorbs the
// memory read latency while the downstream ready is low.
module pixel_skid_buffer
    import image_proc_pkg::*;
(
    input  logic             clk,
    input  logic             reset_n,
    input  logic             push,
    input  logic [PIX_W-1:0] push_data,
    input  logic             out_ready,
    output logic             out_valid,
    output logic [PIX_W-1:0] out_data,
    output logic             full,
    output logic             almost_full
);

    logic [SKID_CNT_W-1:0] cnt_q, cnt_d, cnt_mid;
    pixel_t                ent_q [SKID_DEPTH];
    pixel_t                ent_d [SKID_DEPTH];
    logic                  pop;

    // Entry 0 is the output register; pop shifts down, push lands behind the last entry.
    always_comb begin
        ent_d   = ent_q;
        pop     = (cnt_q != '0) && out_ready;
        cnt_mid = cnt_q;
        if (pop) begin
            for (int i = 0; i < SKID_DEPTH - 1; i++) begin
                ent_d[i] = ent_q[i+1];
            end
            cnt_mid = cnt_q - SKID_CNT_W'(1);
        end
        cnt_d = cnt_mid;
        if (push) begin
            for (int i = 0; i < SKID_DEPTH; i++) begin
                if (cnt_mid == SKID_CNT_W'(i)) begin
                    ent_d[i] = push_data;
                end
            end
            cnt_d = cnt_mid + SKID_CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
            for (int i = 0; i < SKID_DEPTH; i++) begin
                ent_q[i] <= '0;
            end
        end else begin
            cnt_q <= cnt_d;
            ent_q <= ent_d;
        end
    end

    assign out_valid   = (cnt_q != '0);
    assign out_data    = ent_q[0];
    assign full        = (cnt_q == SKID_CNT_W'(SKID_DEPTH));
    assign almost_full = (cnt_q == SKID_CNT_W'(SKID_DEPTH - 1));

endmodule

// File: rtl/image_line_feeder.sv
// Streams a grayscale frame from synchronous frame memory to the line-buffered filter, paced by
// intr_in credits. Define LINE_FEEDER_PAD_REPLICATE_EN to pad by re-reading the last image row.
module image_line_feeder
    import image_proc_pkg::*;
#(
    parameter int unsigned IMAGE_WIDTH   = 512,
    parameter int unsigned IW_BIT_NUM    = 9,
    parameter int unsigned IMAGE_HEIGHT  = 512,
    parameter int unsigned PRELOAD_LINES = 4,
    parameter int unsigned PAD_LINES     = 2,
    parameter int unsigned ADDR_W        = 18
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [PIX_W-1:0]  mem_rd_data,
    output logic              m_data_valid,
    output logic [PIX_W-1:0]  m_data,
    input  logic              m_data_ready,
    input  logic              intr_in
);

    localparam int unsigned ROW_W = $clog2(IMAGE_HEIGHT + 1);
    localparam int unsigned PAD_W = $clog2(PAD_LINES + 2);
    localparam logic [IW_BIT_NUM-1:0] LAST_COL   = IW_BIT_NUM'(IMAGE_WIDTH - 1);
    localparam logic [CREDIT_W-1:0]   CREDIT_MAX = CREDIT_W'(PRELOAD_LINES);
`ifdef LINE_FEEDER_PAD_REPLICATE_EN
    localparam logic [ADDR_W-1:0] LAST_ROW_BASE = ADDR_W'((IMAGE_HEIGHT - 1) * IMAGE_WIDTH);
`endif

    feeder_state_e         state_q, state_d;
    logic [IW_BIT_NUM-1:0] col_q, col_d;
    logic [ROW_W-1:0]      row_q, row_d;
    logic [PAD_W-1:0]      pad_q, pad_d;
    logic [ADDR_W-1:0]     addr_q, addr_d;
    logic [CREDIT_W-1:0]   credit_q, credit_d;
    logic                  intr_q, intr_d;
    rd_tag_t               req_q, req_d;
    rd_tag_t               rsp_q, rsp_d;
    logic                  mem_rd_en_q, mem_rd_en_d;
    logic [ADDR_W-1:0]     mem_addr_q, mem_addr_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;

    logic                  skid_valid, skid_full, skid_almost_full;
    logic [PIX_W-1:0]      skid_data, push_data;
    logic [2:0]            occ, committed;
    logic                  pop, room, issue_state, issue, row_end, pad_state;
    logic                  take, inc, frame_end;

    assign push_data = rsp_q.zero ? '0 : mem_rd_data;

    pixel_skid_buffer u_skid (
        .clk         (clk),
        .reset_n     (reset_n),
        .push        (rsp_q.vld),
        .push_data   (push_data),
        .out_ready   (m_data_ready),
        .out_valid   (skid_valid),
        .out_data    (skid_data),
        .full        (skid_full),
        .almost_full (skid_almost_full)
    );

    always_comb begin
        state_d     = state_q;
        col_d       = col_q;
        row_d       = row_q;
        pad_d       = pad_q;
        addr_d      = addr_q;
        credit_d    = credit_q;
        intr_d      = intr_in;
        req_d       = '0;
        rsp_d       = req_q;
        mem_rd_en_d = 1'b0;
        mem_addr_d  = mem_addr_q;
        done_d      = 1'b0;
        take        = 1'b0;
        frame_end   = 1'b0;

        // A read may issue only if its data is guaranteed a skid slot.
        occ         = skid_full ? 3'd3 : (skid_almost_full ? 3'd2 : (skid_valid ? 3'd1 : 3'd0));
        pop         = skid_valid && m_data_ready;
        committed   = occ - 3'(pop) + 3'(req_q.vld) + 3'(rsp_q.vld);
        room        = (committed < 3'(SKID_DEPTH));
        pad_state   = (state_q == ST_PAD);
        issue_state = (state_q inside {ST_PRELOAD, ST_LINE, ST_PAD}) ||
                      ((state_q == ST_IDLE) && start);
        issue       = issue_state && room;
        row_end     = issue && (col_q == LAST_COL);

        if (issue) begin
            col_d     = row_end ? '0 : col_q + IW_BIT_NUM'(1);
            req_d.vld = 1'b1;
            if (pad_state) begin
                if (row_end) begin
                    pad_d = pad_q + PAD_W'(1);
                end
`ifdef LINE_FEEDER_PAD_REPLICATE_EN
                mem_rd_en_d = 1'b1;
                mem_addr_d  = LAST_ROW_BASE + ADDR_W'(col_q);
`else
                req_d.zero  = 1'b1;
`endif
            end else begin
                mem_rd_en_d = 1'b1;
                mem_addr_d  = addr_q;
                addr_d      = addr_q + ADDR_W'(1);
                if (row_end) begin
                    row_d = row_q + ROW_W'(1);
                end
            end
        end

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_PRELOAD;
                end
            end
            ST_PRELOAD: begin
                if (row_end && (row_q == ROW_W'(PRELOAD_LINES - 1))) begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (row_q == ROW_W'(IMAGE_HEIGHT)) begin
                    state_d = ST_PAD_WAIT;
                end else if (credit_q != '0) begin
                    state_d = ST_LINE;
                    take    = 1'b1;
                end
            end
            ST_LINE: begin
                if (row_end) begin
                    state_d = ST_WAIT;
                end
            end
            ST_PAD_WAIT: begin
                if (pad_q == PAD_W'(PAD_LINES)) begin
                    state_d = ST_DRAIN;
                end else if (credit_q != '0) begin
                    state_d = ST_PAD;
                    take    = 1'b1;
                end
            end
            ST_PAD: begin
                if (row_end) begin
                    state_d = ST_PAD_WAIT;
                end
            end
            ST_DRAIN: begin
                if (!skid_valid && !req_q.vld && !rsp_q.vld) begin
                    state_d   = ST_IDLE;
                    done_d    = 1'b1;
                    frame_end = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Saturating line credits; edges before the preload completes are not counted.
        inc = intr_in && !intr_q && !(state_q inside {ST_IDLE, ST_PRELOAD});
        if (inc && !take) begin
            if (credit_q < CREDIT_MAX) begin
                credit_d = credit_q + CREDIT_W'(1);
            end
        end else if (take && !inc) begin
            credit_d = credit_q - CREDIT_W'(1);
        end

        if (frame_end) begin
            col_d    = '0;
            row_d    = '0;
            pad_d    = '0;
            addr_d   = '0;
            credit_d = '0;
        end

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            col_q       <= '0;
            row_q       <= '0;
            pad_q       <= '0;
            addr_q      <= '0;
            credit_q    <= '0;
            intr_q      <= 1'b0;
            req_q       <= '0;
            rsp_q       <= '0;
            mem_rd_en_q <= 1'b0;
            mem_addr_q  <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            col_q       <= col_d;
            row_q       <= row_d;
            pad_q       <= pad_d;
            addr_q      <= addr_d;
            credit_q    <= credit_d;
            intr_q      <= intr_d;
            req_q       <= req_d;
            rsp_q       <= rsp_d;
            mem_rd_en_q <= mem_rd_en_d;
            mem_addr_q  <= mem_addr_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign busy         = busy_q;
    assign done         = done_q;
    assign mem_rd_en    = mem_rd_en_q;
    assign mem_addr     = mem_addr_q;
    assign m_data_valid = skid_valid;
    assign m_data       = skid_data;

endmodule
